// File: rtl/wbc_pvic_pkg.sv
// Shared definitions for the parametrised vectored interrupt controller.
//  vi_state_t : vector fetch handshake states
//  REG_MASK / REG_PEND : Wishbone register offsets (wb_adr_i)
//  ptr_w()    : width of a channel index, at least one bit
package wbc_pvic_pkg;

    typedef enum logic [1:0] {
        VI_IDLE = 2'd0,
        VI_ACK  = 2'd1,
        VI_DROP = 2'd2
    } vi_state_t;

    localparam logic REG_MASK = 1'b0;
    localparam logic REG_PEND = 1'b1;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wbc_pvic_arb.sv
// Combinational interrupt arbiter.
//  req    : pending requests (already masked)
//  ptr    : round-robin start index (ignored when RR=0)
//  valid  : at least one request pending
//  winner : granted channel index
// RR=0 grants the lowest set index. RR=1 first looks at indices >= ptr,
// then wraps to the whole vector, so the first hit of the second pass is
// the lowest index below ptr.
module pvic_arb #(
    parameter int N  = 3,
    parameter bit RR = 1'b0,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] winner
);

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (!RR || (PW'(i) >= ptr))) begin
                valid  = 1'b1;
                winner = PW'(i);
            end
        end
        if (RR) begin
            for (int i = 0; i < N; i++) begin
                if (!valid && req[i]) begin
                    valid  = 1'b1;
                    winner = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/wbc_pvic.sv
// Parametrised vectored interrupt controller.
//  wb_*     : register port; adr 0 = enable mask (R/W), adr 1 = pending (RO)
//  vi_stb_i/vi_una_i : CPU vector fetch strobe and address-less read qualifier
//  vi_ack_o/vi_dat_o : one-cycle fetch ack and returned vector / una word
//  vi_irq_o : registered OR of masked requests
//  rsel     : word returned on una reads
//  ivec     : per-channel vectors, channel k at ivec[16k +: 16]
//  ireq     : level requests; iack : one-cycle grant pulse, aligned with vi_ack_o
module wbc_pvic
    import wbc_pvic_pkg::*;
#(
    parameter int          N        = 3,
    parameter bit          RR       = 1'b0,
    parameter logic [15:0] ENA_RST  = 16'hFFFF,
    parameter logic [15:0] SPUR_VEC = 16'o0
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wb_adr_i,
    input  logic [15:0]     wb_dat_i,
    output logic [15:0]     wb_dat_o,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [1:0]      wb_sel_i,
    output logic            wb_ack_o,
    input  logic            vi_stb_i,
    input  logic            vi_una_i,
    output logic            vi_ack_o,
    output logic [15:0]     vi_dat_o,
    output logic            vi_irq_o,
    input  logic [15:0]     rsel,
    input  logic [16*N-1:0] ivec,
    input  logic [N-1:0]    ireq,
    output logic [N-1:0]    iack
);

    localparam int PW = ptr_w(N);

    logic [N-1:0]  mask;
    logic [N-1:0]  pend;
    logic [N-1:0]  mask_nxt;
    logic [15:0]   mask_w16;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          win_vld;
    logic          wb_go;
    vi_state_t     state;

    assign pend  = ireq & mask;
    assign wb_go = wb_stb_i & wb_cyc_i & ~wb_ack_o;

    // Byte-lane merge on the full 16-bit view; bits >= N simply fall away.
    always_comb begin
        mask_w16 = 16'(mask);
        if (wb_sel_i[0]) mask_w16[7:0]  = wb_dat_i[7:0];
        if (wb_sel_i[1]) mask_w16[15:8] = wb_dat_i[15:8];
        mask_nxt = mask_w16[N-1:0];
    end

    pvic_arb #(.N(N), .RR(RR), .PW(PW)) u_arb (
        .req    (pend),
        .ptr    (ptr),
        .valid  (win_vld),
        .winner (win)
    );

    // Register port and interrupt line.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            mask     <= ENA_RST[N-1:0];
            vi_irq_o <= 1'b0;
        end else begin
            vi_irq_o <= |pend;
            wb_ack_o <= wb_go;
            if (wb_go) begin
                if (wb_we_i) begin
                    if (wb_adr_i == REG_MASK) mask <= mask_nxt;
                end else begin
                    wb_dat_o <= (wb_adr_i == REG_MASK) ? 16'(mask) : 16'(pend);
                end
            end
        end
    end

    // Vector fetch handshake. The winner is taken from the pre-write mask
    // because pend is built from the registered mask of this cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= VI_IDLE;
            vi_ack_o <= 1'b0;
            vi_dat_o <= '0;
            iack     <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                VI_IDLE: begin
                    if (vi_stb_i) begin
                        vi_ack_o <= 1'b1;
                        state    <= VI_ACK;
                        if (vi_una_i) begin
                            vi_dat_o <= rsel;
                        end else if (win_vld) begin
                            vi_dat_o  <= ivec[int'(win)*16 +: 16];
                            iack      <= '0;
                            iack[win] <= 1'b1;
                            ptr       <= (int'(win) == N-1) ? '0 : win + 1'b1;
                        end else begin
                            vi_dat_o <= SPUR_VEC;
                        end
                    end
                end
                VI_ACK: begin
                    vi_ack_o <= 1'b0;
                    iack     <= '0;
                    state    <= VI_DROP;
                end
                VI_DROP: begin
                    if (!vi_stb_i) state <= VI_IDLE;
                end
                default: state <= VI_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbc_pvic.sv
// Self-checking bench: a fixed-priority and a round-robin instance share all
// inputs and are checked against a scan-based reference model.
module tb_wbc_pvic;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_adr = 1'b0;
    logic [15:0] wb_dat_i = '0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [1:0]  wb_sel = '0;
    logic        vi_stb = 1'b0, vi_una = 1'b0;
    logic [15:0] rsel = '0;
    logic [47:0] ivec = {16'o64, 16'o60, 16'o54};
    logic [2:0]  ireq = '0;

    logic [15:0] wdo0, wdo1, vdat0, vdat1;
    logic        wack0, wack1, vack0, vack1, virq0, virq1;
    logic [2:0]  iack0, iack1;

    localparam logic [15:0] SPUR1 = 16'o4;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [2:0]  mask_m;
    int          ptr_m;
    logic [15:0] vtab [3] = '{16'o54, 16'o60, 16'o64};

    always #5 clk = ~clk;

    wbc_pvic #(.N(3), .RR(1'b0)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wdo0), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_sel_i(wb_sel), .wb_ack_o(wack0), .vi_stb_i(vi_stb), .vi_una_i(vi_una),
        .vi_ack_o(vack0), .vi_dat_o(vdat0), .vi_irq_o(virq0), .rsel(rsel),
        .ivec(ivec), .ireq(ireq), .iack(iack0)
    );

    wbc_pvic #(.N(3), .RR(1'b1), .SPUR_VEC(SPUR1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wdo1), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_sel_i(wb_sel), .wb_ack_o(wack1), .vi_stb_i(vi_stb), .vi_una_i(vi_una),
        .vi_ack_o(vack1), .vi_dat_o(vdat1), .vi_irq_o(virq1), .rsel(rsel),
        .ivec(ivec), .ireq(ireq), .iack(iack1)
    );

    // Reference arbitration: scan channels in priority order from the start point.
    function automatic int pick(input logic [2:0] p, input bit rr, input int start);
        for (int j = 0; j < 3; j++) begin
            int k;
            k = rr ? (start + j) % 3 : j;
            if (p[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_mask(input logic [2:0] m, input logic [15:0] d,
                                              input logic [1:0] s);
        logic [15:0] w;
        w = {13'd0, m};
        if (s[0]) w[7:0]  = d[7:0];
        if (s[1]) w[15:8] = d[15:8];
        return w[2:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vi_stb = 1'b0; vi_una = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        mask_m = 3'b111; ptr_m = 0;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wb_write(input logic adr, input logic [15:0] d, input logic [1:0] s);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat_i = d; wb_sel = s;
        @(posedge clk); #1;
        n_chk++;
        if ({wack0, wack1} !== 2'b11) begin
            n_fail++; $display("FAIL wb_write_ack: got %b want 11", {wack0, wack1});
        end
        if (adr == 1'b0) mask_m = model_mask(mask_m, d, s);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk);
    endtask

    task automatic wb_read_chk(input logic adr, input logic [15:0] exp, input string nm);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
        @(posedge clk); #1;
        n_chk++;
        if ({wack0, wack1, wdo0, wdo1} !== {2'b11, exp, exp}) begin
            n_fail++;
            $display("FAIL %s: ack=%b%b d0=%h d1=%h want d=%h", nm, wack0, wack1, wdo0, wdo1, exp);
        end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if ({wack0, wack1} !== 2'b00) begin
            n_fail++; $display("FAIL %s_ack_low: got %b want 00", nm, {wack0, wack1});
        end
    endtask

    // Full fetch on both instances; ireq must already be applied.
    task automatic fetch(input logic una, input logic [15:0] rs, input string nm);
        logic [2:0]  p;
        int          w0, w1;
        logic [15:0] e0, e1;
        logic [2:0]  a0, a1;
        p  = ireq & mask_m;
        w0 = pick(p, 1'b0, 0);
        w1 = pick(p, 1'b1, ptr_m);
        e0 = una ? rs : (w0 < 0 ? 16'o0 : vtab[w0]);
        e1 = una ? rs : (w1 < 0 ? SPUR1 : vtab[w1]);
        a0 = (una || w0 < 0) ? 3'b000 : 3'(1 << w0);
        a1 = (una || w1 < 0) ? 3'b000 : 3'(1 << w1);
        @(negedge clk);
        vi_stb = 1'b1; vi_una = una; rsel = rs;
        @(posedge clk); #1;
        n_chk++;
        if ({vack0, vdat0, iack0, virq0} !== {1'b1, e0, a0, |p}) begin
            n_fail++;
            $display("FAIL %s_fixed: ack=%b dat=%o iack=%b irq=%b want 1 %o %b %b",
                     nm, vack0, vdat0, iack0, virq0, e0, a0, |p);
        end
        n_chk++;
        if ({vack1, vdat1, iack1} !== {1'b1, e1, a1}) begin
            n_fail++;
            $display("FAIL %s_rr: ack=%b dat=%o iack=%b want 1 %o %b (ptr %0d)",
                     nm, vack1, vdat1, iack1, e1, a1, ptr_m);
        end
        if (!una && w1 >= 0) ptr_m = (w1 + 1) % 3;
        @(posedge clk); #1;
        n_chk++;
        if ({vack0, iack0, vack1, iack1, vdat0, vdat1} !== {1'b0, 3'b000, 1'b0, 3'b000, e0, e1}) begin
            n_fail++;
            $display("FAIL %s_pulse_end: ack=%b%b iack=%b/%b dat=%o/%o", nm, vack0, vack1,
                     iack0, iack1, vdat0, vdat1);
        end
        @(negedge clk);
        vi_stb = 1'b0; vi_una = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        ireq = 3'b000;
        do_reset();
        n_chk++;
        if ({wack0, wdo0, vack0, vdat0, virq0, iack0, wack1, vack1, iack1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: wack=%b wdo=%h vack=%b vdat=%o irq=%b iack=%b",
                     wack0, wdo0, vack0, vdat0, virq0, iack0);
        end
        wb_read_chk(1'b0, 16'h0007, "reset_mask");
    endtask

    task automatic test_fixed();
        @(negedge clk) ireq = 3'b111;
        #1 n_chk++;
        if (virq0 !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", virq0); end
        @(posedge clk); #1 n_chk++;
        if (virq0 !== 1'b1) begin n_fail++; $display("FAIL irq_latency: got %b want 1", virq0); end
        fetch(1'b0, 16'h0, "fixed_111");
    endtask

    task automatic test_mask();
        wb_write(1'b0, 16'h0006, 2'b11);
        @(negedge clk) ireq = 3'b001;
        @(posedge clk); @(posedge clk); #1 n_chk++;
        if ({virq0, virq1} !== 2'b00) begin
            n_fail++; $display("FAIL mask_irq: got %b want 00", {virq0, virq1});
        end
        wb_read_chk(1'b1, 16'h0000, "pend_masked");
        wb_read_chk(1'b0, 16'h0006, "mask_rd");
        wb_write(1'b1, 16'h0000, 2'b11);
        wb_read_chk(1'b0, 16'h0006, "pend_write_ignored");
        wb_write(1'b0, 16'hFF05, 2'b01);
        wb_read_chk(1'b0, 16'h0005, "mask_lo_lane");
        ireq = 3'b111;
        wb_read_chk(1'b1, 16'h0005, "pend_rd");
    endtask

    task automatic test_rr();
        do_reset();
        ireq = 3'b111;
        for (int i = 0; i < 4; i++) fetch(1'b0, 16'h0, "rr_seq");
        n_chk++;
        if (ptr_m !== 1) begin n_fail++; $display("FAIL rr_model_ptr: got %0d want 1", ptr_m); end
    endtask

    task automatic test_una_spur();
        ireq = 3'b111;
        fetch(1'b1, 16'o177716, "una");
        fetch(1'b0, 16'h0, "after_una");
        ireq = 3'b000;
        fetch(1'b0, 16'h0, "spurious");
        ireq = 3'b110;
        fetch(1'b0, 16'h0, "after_spur");
    endtask

    task automatic test_hold();
        int c0, c1;
        logic [2:0] p;
        c0 = 0; c1 = 0;
        p = 3'b111 & mask_m;
        @(negedge clk);
        ireq = 3'b111; vi_stb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            c0 += int'(vack0); c1 += int'(vack1);
        end
        if (pick(p, 1'b1, ptr_m) >= 0) ptr_m = (pick(p, 1'b1, ptr_m) + 1) % 3;
        n_chk++;
        if (c0 != 1 || c1 != 1) begin
            n_fail++; $display("FAIL held_stb_acks: got %0d/%0d want 1/1", c0, c1);
        end
        @(negedge clk) vi_stb = 1'b0;
        @(posedge clk);
        fetch(1'b0, 16'h0, "after_hold");
    endtask

    task automatic test_concurrent();
        do_reset();
        @(negedge clk);
        ireq = 3'b001; vi_stb = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 1'b0; wb_dat_i = 16'h0006; wb_sel = 2'b11;
        @(posedge clk); #1;
        n_chk++;
        if ({vdat0, iack0, vdat1, iack1, wack0} !== {16'o54, 3'b001, 16'o54, 3'b001, 1'b1}) begin
            n_fail++;
            $display("FAIL old_mask_latch: dat=%o/%o iack=%b/%b wack=%b want 54 001", vdat0, vdat1,
                     iack0, iack1, wack0);
        end
        mask_m = 3'b110; ptr_m = 1;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; ireq = 3'b000;
        @(posedge clk); #1;
        n_chk++;
        if ({vack0, iack0} !== 4'b0) begin
            n_fail++; $display("FAIL concur_pulse_end: ack=%b iack=%b", vack0, iack0);
        end
        @(negedge clk) vi_stb = 1'b0;
        @(posedge clk);
        wb_read_chk(1'b0, 16'h0006, "concur_mask");
    endtask

    task automatic test_reset_in_ack();
        wb_write(1'b0, 16'h0002, 2'b11);
        @(negedge clk);
        ireq = 3'b111; vi_stb = 1'b1;
        @(posedge clk); #1 n_chk++;
        if ({vack0, iack0} !== 4'b1010) begin
            n_fail++; $display("FAIL ack_before_rst: ack=%b iack=%b want 1 010", vack0, iack0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 n_chk++;
        if ({vack0, iack0, vack1, iack1, virq0} !== '0) begin
            n_fail++;
            $display("FAIL rst_in_ack: ack=%b%b iack=%b/%b irq=%b want 0", vack0, vack1, iack0, iack1, virq0);
        end
        @(negedge clk);
        rst = 1'b0; vi_stb = 1'b0; mask_m = 3'b111; ptr_m = 0;
        @(posedge clk);
        wb_read_chk(1'b0, 16'h0007, "mask_after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                wb_write(1'b0, 16'($urandom), 2'($urandom_range(1, 3)));
            ireq = 3'($urandom);
            fetch($urandom_range(0, 4) == 0, 16'($urandom), "random");
        end
        ireq = 3'($urandom);
        wb_read_chk(1'b1, {13'd0, ireq & mask_m}, "random_pend");
    endtask

    initial begin
        mask_m = 3'b111; ptr_m = 0;
        test_reset();
        test_fixed();
        test_mask();
        test_rr();
        test_una_spur();
        test_hold();
        test_concurrent();
        test_reset_in_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
